// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types for the store path between the store data queue (SDQ) and the
// data-memory port:
//   mem_size_e    : access size of a store (BYTE, HALF, WORD).
//   sdq_entry_t   : store as issued by the SDQ (address, data, size).
//   wb_entry_t    : write-buffer entry after lane formation (word address,
//                   lane data, byte enables, SDQ index, misaligned flag).
//   drain_state_e : states of the store drain FSM.
//   form_lanes()  : turns an issued store into a write-buffer entry.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_XLEN    = 32;
  localparam int SDQ_ENTRIES = 8;
  localparam int SDQ_IDX_W   = $clog2(SDQ_ENTRIES);

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [MEM_XLEN-1:0] addr;
    logic [MEM_XLEN-1:0] data;
    mem_size_e           size;
  } sdq_entry_t;

  typedef struct packed {
    logic [MEM_XLEN-3:0]  waddr;
    logic [MEM_XLEN-1:0]  data;
    logic [3:0]           be;
    logic [SDQ_IDX_W-1:0] sdq_idx;
    logic                 misaligned;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DROP     = 2'd3
  } drain_state_e;

  // Narrow stores are replicated across the word so the memory only has to
  // honour the byte enables; the low address bits select the enabled lanes.
  function automatic wb_entry_t form_lanes(input sdq_entry_t           st,
                                           input logic [SDQ_IDX_W-1:0] idx);
    wb_entry_t e;
    e.waddr      = st.addr[MEM_XLEN-1:2];
    e.sdq_idx    = idx;
    e.misaligned = 1'b0;
    case (st.size)
      BYTE: begin
        e.be   = 4'b0001 << st.addr[1:0];
        e.data = {4{st.data[7:0]}};
      end
      HALF: begin
        e.be         = 4'b0011 << st.addr[1:0];
        e.data       = {2{st.data[15:0]}};
        e.misaligned = st.addr[0];
      end
      default: begin
        e.be         = 4'b1111;
        e.data       = st.data;
        e.misaligned = |st.addr[1:0];
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/store_drain_buf.sv
// -----------------------------------------------------------------------------
// store_drain_buf
// In-order circular write buffer for the store drain unit. Pointers carry one
// extra MSB so that head == tail means empty and a differing MSB with equal
// index bits means full.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset.
//   i_push        : write i_push_entry at the tail (ignored when full).
//   i_push_entry  : entry to enqueue.
//   i_pop         : retire the head entry.
//   o_full        : buffer holds DEPTH entries.
//   o_empty       : buffer holds no entries.
//   o_head        : oldest entry (valid when !o_empty).
//   o_entries     : every storage slot, for the load address check.
//   o_live        : per-slot flag, slot lies between head and tail-1.
// -----------------------------------------------------------------------------
module store_drain_buf
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  wb_entry_t        i_push_entry,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output wb_entry_t        o_head,
  output wb_entry_t        o_entries [DEPTH],
  output logic [DEPTH-1:0] o_live
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] w_count;
  logic             w_push_ok;

  assign o_empty   = (r_head == r_tail);
  assign o_full    = (r_head[IDX_W] != r_tail[IDX_W]) &&
                     (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]);
  assign w_count   = r_tail - r_head;
  assign w_push_ok = i_push && !o_full;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)     r_head <= r_head + PTR_W'(1);
    end
  end

  // NOTE: the storage array has no reset; a slot is only ever read while
  // o_live marks it, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_tail[IDX_W-1:0]] <= i_push_entry;
  end

  assign o_head = r_mem[r_head[IDX_W-1:0]];

  // A slot is live when its distance from head (modulo DEPTH) is less than
  // the occupancy; this covers the in-flight head as well.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [IDX_W-1:0] w_off;
    assign w_off        = IDX_W'(g) - r_head[IDX_W-1:0];
    assign o_live[g]    = ({1'b0, w_off} < w_count);
    assign o_entries[g] = r_mem[g];
  end

endmodule

// File: rtl/store_drain_unit.sv
// -----------------------------------------------------------------------------
// store_drain_unit
// Consumer end of the SDQ issue port. Accepts committed stores, forms byte
// lanes, buffers them in order and performs one byte-masked write at a time
// to the data-memory port. Each completed or dropped store returns its SDQ
// index on sdq_free_vld/sdq_free_idx.
// Optional feature: define STORE_DRAIN_FWD_EN to enable the load overlap
// check; otherwise ld_chk_hit is tied low.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset.
//   st_valid/st_entry/
//   st_sdq_idx/st_ready      : store issue handshake from the SDQ.
//   dmem_req/addr/wdata/be   : registered write request to the D-memory.
//   dmem_gnt, dmem_ack       : request accepted, write complete.
//   sdq_free_vld/idx         : one-cycle release of an SDQ entry.
//   misalign_err             : one-cycle pulse when a misaligned store drops.
//   ld_chk_vld/addr/hit      : combinational load-vs-pending-store check.
// -----------------------------------------------------------------------------
module store_drain_unit
  import mem_pkg::*;
#(
  parameter int BUF_ENTRIES = 4,
  parameter int XLEN        = MEM_XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  input  sdq_entry_t           st_entry,
  input  logic [SDQ_IDX_W-1:0] st_sdq_idx,
  output logic                 st_ready,
  output logic                 dmem_req,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_gnt,
  input  logic                 dmem_ack,
  output logic                 sdq_free_vld,
  output logic [SDQ_IDX_W-1:0] sdq_free_idx,
  output logic                 misalign_err,
  input  logic                 ld_chk_vld,
  input  logic [XLEN-1:0]      ld_chk_addr,
  output logic                 ld_chk_hit
);

  drain_state_e         r_state;
  logic                 r_dmem_req;
  logic [XLEN-1:0]      r_dmem_addr;
  logic [XLEN-1:0]      r_dmem_wdata;
  logic [3:0]           r_dmem_be;
  logic                 r_sdq_free_vld;
  logic [SDQ_IDX_W-1:0] r_sdq_free_idx;
  logic                 r_misalign_err;

  drain_state_e         w_nxt_state;
  logic                 w_nxt_req;
  logic [XLEN-1:0]      w_nxt_addr;
  logic [XLEN-1:0]      w_nxt_wdata;
  logic [3:0]           w_nxt_be;
  logic                 w_nxt_free_vld;
  logic [SDQ_IDX_W-1:0] w_nxt_free_idx;
  logic                 w_nxt_misalign;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_st_fire;
  logic                 w_pop;
  wb_entry_t            w_new_entry;
  wb_entry_t            w_head;
  wb_entry_t            w_cand;
  logic                 w_cand_vld;
  wb_entry_t            w_rd_entries [BUF_ENTRIES];
  logic [BUF_ENTRIES-1:0] w_live;

  assign st_ready    = !w_full;
  assign w_st_fire   = st_valid && !w_full;
  assign w_new_entry = form_lanes(st_entry, st_sdq_idx);

  store_drain_buf #(
    .DEPTH (BUF_ENTRIES)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_st_fire),
    .i_push_entry (w_new_entry),
    .i_pop        (w_pop),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head       (w_head),
    .o_entries    (w_rd_entries),
    .o_live       (w_live)
  );

  // With the buffer empty the incoming store is examined directly so its
  // request can be registered in the same cycle it is accepted. It is
  // enqueued on that edge, so it is the buffer head once REQ/DROP is entered.
  assign w_cand_vld = !w_empty || w_st_fire;
  assign w_cand     = w_empty ? w_new_entry : w_head;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_nxt_state    = r_state;
    w_nxt_req      = r_dmem_req;
    w_nxt_addr     = r_dmem_addr;
    w_nxt_wdata    = r_dmem_wdata;
    w_nxt_be       = r_dmem_be;
    w_nxt_free_vld = 1'b0;
    w_nxt_free_idx = r_sdq_free_idx;
    w_nxt_misalign = 1'b0;
    w_pop          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_cand_vld) begin
          if (w_cand.misaligned) begin
            w_nxt_state = ST_DROP;
          end else begin
            w_nxt_state = ST_REQ;
            w_nxt_req   = 1'b1;
            w_nxt_addr  = {w_cand.waddr, 2'b00};
            w_nxt_wdata = w_cand.data;
            w_nxt_be    = w_cand.be;
          end
        end
      end

      ST_REQ: begin
        // An ack without a grant is a protocol violation and is ignored.
        if (dmem_gnt) begin
          w_nxt_req = 1'b0;
          if (dmem_ack) begin
            w_pop          = 1'b1;
            w_nxt_free_vld = 1'b1;
            w_nxt_free_idx = w_head.sdq_idx;
            w_nxt_state    = ST_IDLE;
          end else begin
            w_nxt_state = ST_WAIT_ACK;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (dmem_ack) begin
          w_pop          = 1'b1;
          w_nxt_free_vld = 1'b1;
          w_nxt_free_idx = w_head.sdq_idx;
          w_nxt_state    = ST_IDLE;
        end
      end

      ST_DROP: begin
        w_pop          = 1'b1;
        w_nxt_free_vld = 1'b1;
        w_nxt_free_idx = w_head.sdq_idx;
        w_nxt_misalign = 1'b1;
        w_nxt_state    = ST_IDLE;
      end

      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // NOTE: the reset is asynchronous, so an in-flight write is abandoned and
  // every registered output returns to its reset value without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_dmem_req     <= 1'b0;
      r_dmem_addr    <= '0;
      r_dmem_wdata   <= '0;
      r_dmem_be      <= '0;
      r_sdq_free_vld <= 1'b0;
      r_sdq_free_idx <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      r_state        <= w_nxt_state;
      r_dmem_req     <= w_nxt_req;
      r_dmem_addr    <= w_nxt_addr;
      r_dmem_wdata   <= w_nxt_wdata;
      r_dmem_be      <= w_nxt_be;
      r_sdq_free_vld <= w_nxt_free_vld;
      r_sdq_free_idx <= w_nxt_free_idx;
      r_misalign_err <= w_nxt_misalign;
    end
  end

  assign dmem_req     = r_dmem_req;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_wdata   = r_dmem_wdata;
  assign dmem_be      = r_dmem_be;
  assign sdq_free_vld = r_sdq_free_vld;
  assign sdq_free_idx = r_sdq_free_idx;
  assign misalign_err = r_misalign_err;

`ifdef STORE_DRAIN_FWD_EN
  // A load replays when any live, aligned pending store touches its word.
  logic w_fwd_hit;
  logic w_unused_ld_lsb;

  always_comb begin
    w_fwd_hit = 1'b0;
    for (int i = 0; i < BUF_ENTRIES; i++) begin
      if (w_live[i] && !w_rd_entries[i].misaligned && (|w_rd_entries[i].be) &&
          (w_rd_entries[i].waddr == ld_chk_addr[XLEN-1:2])) begin
        w_fwd_hit = 1'b1;
      end
    end
  end

  assign ld_chk_hit      = ld_chk_vld && w_fwd_hit;
  assign w_unused_ld_lsb = ^ld_chk_addr[1:0];
`else
  logic [BUF_ENTRIES-1:0] w_unused_rd;
  logic                   w_unused_ld;

  assign ld_chk_hit  = 1'b0;
  assign w_unused_ld = ^{ld_chk_vld, ld_chk_addr};

  for (genvar g = 0; g < BUF_ENTRIES; g++) begin : g_unused
    assign w_unused_rd[g] = ^{w_rd_entries[g], w_live[g]};
  end
`endif

endmodule

// File: tb/tb_store_drain_unit.sv
module tb_store_drain_unit;
  import mem_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 st_valid;
  sdq_entry_t           st_entry;
  logic [SDQ_IDX_W-1:0] st_sdq_idx;
  logic                 st_ready;
  logic                 dmem_req;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic [3:0]           dmem_be;
  logic                 dmem_gnt;
  logic                 dmem_ack;
  logic                 sdq_free_vld;
  logic [SDQ_IDX_W-1:0] sdq_free_idx;
  logic                 misalign_err;
  logic                 ld_chk_vld;
  logic [31:0]          ld_chk_addr;
  logic                 ld_chk_hit;

  int checks = 0;
  int errors = 0;

  store_drain_unit #(.BUF_ENTRIES(4), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_entry     (st_entry),
    .st_sdq_idx   (st_sdq_idx),
    .st_ready     (st_ready),
    .dmem_req     (dmem_req),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_gnt     (dmem_gnt),
    .dmem_ack     (dmem_ack),
    .sdq_free_vld (sdq_free_vld),
    .sdq_free_idx (sdq_free_idx),
    .misalign_err (misalign_err),
    .ld_chk_vld   (ld_chk_vld),
    .ld_chk_addr  (ld_chk_addr),
    .ld_chk_hit   (ld_chk_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model: stores as the SDQ issued them, lanes derived arithmetically
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned size;
    logic [2:0]  idx;
  } mst_t;

  mst_t pend[$];

  function automatic logic m_mis(input mst_t s);
    int unsigned nb = 1 << s.size;
    return ((s.addr % nb) != 0);
  endfunction

  function automatic logic [3:0] m_be(input mst_t s);
    int unsigned nb   = 1 << s.size;
    int unsigned bits = ((1 << nb) - 1) << (s.addr % 4);
    return bits[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input mst_t s);
    int unsigned nb = 1 << s.size;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = s.data[8*(k % nb) +: 8];
    return w;
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
`ifdef STORE_DRAIN_FWD_EN
    foreach (pend[i]) begin
      if (!m_mis(pend[i]) && (pend[i].addr[31:2] == a[31:2])) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                             input int unsigned sz, input logic [2:0] idx);
    st_valid       = 1'b1;
    st_entry.addr  = a;
    st_entry.data  = d;
    st_entry.size  = mem_size_e'(sz[1:0]);
    st_sdq_idx     = idx;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_st_ready"},  st_ready, 1);
    check({pfx, "_req"},       dmem_req, 0);
    check({pfx, "_addr"},      dmem_addr, 0);
    check({pfx, "_wdata"},     dmem_wdata, 0);
    check({pfx, "_be"},        dmem_be, 0);
    check({pfx, "_free_vld"},  sdq_free_vld, 0);
    check({pfx, "_free_idx"},  sdq_free_idx, 0);
    check({pfx, "_misalign"},  misalign_err, 0);
  endtask

  task automatic wait_req(input string tag, input int budget);
    for (int n = 0; n < budget && !dmem_req; n++) tick();
    check(tag, dmem_req, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Randomized phase: one cycle of stimulus and transaction-level checking
  // ---------------------------------------------------------------------------
  mst_t acc;
  bit   have_acc    = 0;
  bit   outstanding = 0;
  bit   acked_prev  = 0;
  int   ack_wait    = 0;

  task automatic rand_cycle(input bit allow_st);
    mst_t s;
    int   d;
    if (have_acc) begin
      pend.push_back(acc);
      have_acc = 0;
    end
    if (acked_prev) check("r_req_after_ack", dmem_req, 0);
    acked_prev = 0;

    if (sdq_free_vld) begin
      if (pend.size() == 0) begin
        check("r_free_unexpected", sdq_free_vld, 0);
      end else begin
        check("r_free_idx", sdq_free_idx, pend[0].idx);
        check("r_misalign_flag", misalign_err, m_mis(pend[0]));
        void'(pend.pop_front());
      end
    end else begin
      check("r_misalign_alone", misalign_err, 0);
    end

    dmem_gnt = 1'b0;
    dmem_ack = 1'b0;
    if (outstanding) begin
      check("r_req_outstanding", dmem_req, 0);
      if (ack_wait == 0) begin
        dmem_ack    = 1'b1;
        outstanding = 0;
        acked_prev  = 1;
      end else begin
        ack_wait--;
      end
    end else if (dmem_req) begin
      if (pend.size() == 0) begin
        check("r_req_unexpected", dmem_req, 0);
      end else if ($urandom_range(0, 2) != 0) begin
        check("r_req_for_dropped", dmem_req, m_mis(pend[0]) ? 0 : 1);
        check("r_addr",  dmem_addr,  {pend[0].addr[31:2], 2'b00});
        check("r_be",    dmem_be,    m_be(pend[0]));
        check("r_wdata", dmem_wdata, m_wdata(pend[0]));
        dmem_gnt = 1'b1;
        d = $urandom_range(0, 3);
        if (d == 0) begin
          dmem_ack   = 1'b1;
          acked_prev = 1;
        end else begin
          outstanding = 1;
          ack_wait    = d - 1;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        dmem_ack = 1'b1;  // stray ack before grant: must be ignored
      end
    end

    st_valid = 1'b0;
    if (allow_st && ($urandom_range(0, 1) == 1)) begin
      s.addr = 32'h4000 + 4 * $urandom_range(0, 3) +
               (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 3));
      s.data = $urandom;
      s.size = $urandom_range(0, 2);
      s.idx  = 3'($urandom_range(0, 7));
      drive_store(s.addr, s.data, s.size, s.idx);
      if (st_ready) begin
        acc      = s;
        have_acc = 1;
      end
    end

    ld_chk_vld  = 1'($urandom_range(0, 1));
    ld_chk_addr = 32'h4000 + $urandom_range(0, 19);
    #1;
    check("r_ld_hit", ld_chk_hit, ld_chk_vld && m_hit(ld_chk_addr));
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by the randomized phase
  // ---------------------------------------------------------------------------
  logic [31:0] wd [4];
  logic        exp_fwd;

  initial begin
`ifdef STORE_DRAIN_FWD_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    rst         = 1'b1;
    st_valid    = 1'b0;
    st_entry    = '0;
    st_sdq_idx  = '0;
    dmem_gnt    = 1'b0;
    dmem_ack    = 1'b0;
    ld_chk_vld  = 1'b0;
    ld_chk_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_reset_outputs("reset");

    // Single WORD store, separate grant and ack
    drive_store(32'h1000, 32'hDEADBEEF, 2, 3);
    check("t1_ready", st_ready, 1);
    tick();
    st_valid = 1'b0;
    check("t1_req",   dmem_req, 1);
    check("t1_addr",  dmem_addr, 32'h1000);
    check("t1_be",    dmem_be, 4'hF);
    check("t1_wdata", dmem_wdata, 32'hDEADBEEF);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("t1_req_drop", dmem_req, 0);
    check("t1_no_free_yet", sdq_free_vld, 0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("t1_free_vld", sdq_free_vld, 1);
    check("t1_free_idx", sdq_free_idx, 3);
    check("t1_req_k1",   dmem_req, 0);
    tick();
    check("t1_free_pulse", sdq_free_vld, 0);

    // BYTE and HALF lane formation, grant and ack together
    drive_store(32'h1003, 32'h123456AB, 0, 1);
    tick();
    st_valid = 1'b0;
    check("t2b_addr",  dmem_addr, 32'h1000);
    check("t2b_be",    dmem_be, 4'b1000);
    check("t2b_wdata", dmem_wdata, 32'hABABABAB);
    dmem_gnt = 1'b1;
    dmem_ack = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    dmem_ack = 1'b0;
    check("t2b_req_drop", dmem_req, 0);
    check("t2b_free_idx", sdq_free_idx, 1);
    tick();
    drive_store(32'h1002, 32'hFFFF1234, 1, 2);
    tick();
    st_valid = 1'b0;
    check("t2h_be",    dmem_be, 4'b1100);
    check("t2h_wdata", dmem_wdata, 32'h12341234);
    dmem_gnt = 1'b1;
    dmem_ack = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    dmem_ack = 1'b0;
    check("t2h_free_vld", sdq_free_vld, 1);
    check("t2h_free_idx", sdq_free_idx, 2);
    tick();

    // Misaligned HALF is dropped
    drive_store(32'h1001, 32'h5555, 1, 5);
    tick();
    st_valid = 1'b0;
    check("t3_no_req_n1", dmem_req, 0);
    tick();
    check("t3_no_req_n2", dmem_req, 0);
    check("t3_misalign",  misalign_err, 1);
    check("t3_free_vld",  sdq_free_vld, 1);
    check("t3_free_idx",  sdq_free_idx, 5);
    tick();
    check("t3_misalign_pulse", misalign_err, 0);
    check("t3_free_pulse",     sdq_free_vld, 0);

    // Fill with grant held low, drain in order, then refill across the wrap
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      drive_store(32'h3000 + 4 * i, wd[i], 2, 3'(i));
      check("t4_ready_fill", st_ready, 1);
      tick();
    end
    st_valid = 1'b0;
    check("t4_full", st_ready, 0);
    for (int i = 0; i < 4; i++) begin
      wait_req("t4_req_seen", 20);
      check("t4_addr",  dmem_addr, 32'h3000 + 4 * i);
      check("t4_wdata", dmem_wdata, wd[i]);
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      check("t4_free_vld", sdq_free_vld, 1);
      check("t4_free_idx", sdq_free_idx, i);
      check("t4_ready_k1", st_ready, 1);
      check("t4_req_k1",   dmem_req, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h3100 + 4 * i, 32'hA0000000 + i, 2, 3'(4 + i));
      check("t4w_ready_fill", st_ready, 1);
      tick();
    end
    st_valid = 1'b0;
    check("t4w_full", st_ready, 0);
    for (int i = 0; i < 4; i++) begin
      wait_req("t4w_req_seen", 20);
      check("t4w_addr", dmem_addr, 32'h3100 + 4 * i);
      dmem_gnt = 1'b1;
      dmem_ack = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      dmem_ack = 1'b0;
      check("t4w_free_idx", sdq_free_idx, 4 + i);
    end
    tick();
    check("t4w_empty_ready", st_ready, 1);

    // Reset while waiting for an ack with three entries buffered
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h5000 + 4 * i, 32'h11110000 + i, 2, 3'(1 + i));
      tick();
    end
    st_valid = 1'b0;
    wait_req("t5_req_seen", 20);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("t5_wait_ack", dmem_req, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("t5_no_req",  dmem_req, 0);
      check("t5_no_free", sdq_free_vld, 0);
    end

    // Load overlap check against a buffered store
    drive_store(32'h2004, 32'hCAFEF00D, 2, 6);
    tick();
    st_valid    = 1'b0;
    ld_chk_vld  = 1'b1;
    ld_chk_addr = 32'h2006;
    #1;
    check("t6_hit_same_word", ld_chk_hit, exp_fwd);
    ld_chk_addr = 32'h2008;
    #1;
    check("t6_miss_next_word", ld_chk_hit, 0);
    ld_chk_vld  = 1'b0;
    ld_chk_addr = 32'h2006;
    #1;
    check("t6_no_vld", ld_chk_hit, 0);
    dmem_gnt = 1'b1;
    dmem_ack = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    dmem_ack = 1'b0;
    check("t6_free_idx", sdq_free_idx, 6);
    tick();

    // Randomized traffic against the model, then a bounded drain
    for (int n = 0; n < 1500; n++) rand_cycle(1);
    for (int n = 0; n < 400 && (pend.size() != 0 || have_acc || outstanding); n++)
      rand_cycle(0);
    check("r_drained", pend.size(), 0);
    check("r_final_ready", st_ready, 1);
    check("r_final_req", dmem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_drain_unit.md
# store_drain_unit

Store drain unit: the consumer end of the store data queue issue port. Accepts committed, address-resolved stores, buffers them in a small in-order write buffer, and performs one byte-masked write at a time to the data-memory port. On write acknowledgement it returns the SDQ index so the store's SDQ entry can be released. Sits between the SDQ and the D-memory arbiter.

## Interface
Parameters:
- BUF_ENTRIES, 4, write-buffer depth; must be a power of two, at least 2.
- XLEN, 32, address and data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- st_valid  in  1  SDQ presents an issued store this cycle.
- st_entry  in  sdq_entry_t  issued store; uses fields addr, data, size.
- st_sdq_idx  in  $clog2(SDQ_ENTRIES)  SDQ index of the store.
- st_ready  out  1  store accepted when st_valid && st_ready.
- dmem_req  out  1  write request.
- dmem_addr  out  XLEN  word-aligned address, addr[1:0] = 0.
- dmem_wdata  out  XLEN  data shifted into byte lanes.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_ack  in  1  write complete.
- sdq_free_vld  out  1  one-cycle pulse that releases an SDQ entry.
- sdq_free_idx  out  $clog2(SDQ_ENTRIES)  index being released.
- misalign_err  out  1  one-cycle pulse when a misaligned store is dropped.
- ld_chk_vld  in  1  load address check request.
- ld_chk_addr  in  XLEN  load address.
- ld_chk_hit  out  1  combinational; a pending store overlaps the load's word.

## Operation
- Buffer: circular, head/tail pointers of $clog2(BUF_ENTRIES)+1 bits; the MSB distinguishes full from empty. Each entry holds: word address, lane data, be, sdq_idx, misaligned flag.
- st_ready = !full. An enqueue while the buffer is full is not possible. There is no same-cycle enqueue/dequeue bypass when full.
- Lane formation at enqueue:
  - size BYTE: be = 1 << addr[1:0]; data byte replicated to all lanes.
  - size HALF: be = 4'b0011 << addr[1:0]; halfword replicated.
  - size WORD: be = 4'b1111.
- Misaligned stores (HALF with addr[0] = 1, WORD with addr[1:0] != 0) are flagged and never sent to memory.
- FSM states:
  - IDLE: if the buffer is non-empty and head is misaligned, go to DROP; if head is aligned, go to REQ.
  - REQ: dmem_req = 1 with the head fields. On dmem_gnt, go to WAIT_ACK.
  - WAIT_ACK: dmem_req = 0. On dmem_ack, pop head and go to IDLE.
  - DROP: pop head, pulse misalign_err, go to IDLE.
- sdq_free_vld pulses, with the head sdq_idx, on the pop from WAIT_ACK and on the pop from DROP.
- At most one outstanding write. Stores drain in strict program order.
- Buffered stores are architecturally committed and are never flushed.

## Timing
- Reset values: st_ready = 1, dmem_req = 0, dmem_addr/wdata/be = 0, sdq_free_vld = 0, sdq_free_idx = 0, misalign_err = 0. Pointers are 0 and the FSM is in IDLE.
- Reset mid-transaction abandons the in-flight write and empties the buffer. The memory side must also be reset.
- Every output except st_ready and ld_chk_hit is registered.
- Store accepted in cycle N with the buffer empty: dmem_req is high in cycle N+1.
- dmem_gnt in cycle M: dmem_req is low from cycle M+1. dmem_gnt and dmem_ack may be asserted in the same cycle; the unit then treats the write as complete.
- dmem_ack in cycle K: sdq_free_vld is high in cycle K+1 and st_ready rises in K+1 if the buffer was full. The next dmem_req is asserted no earlier than K+2.
- dmem_ack in REQ state before dmem_gnt: protocol violation; the unit ignores it.
- Pointer wrap: the index wraps modulo BUF_ENTRIES and the MSB toggles.

## Configuration
- STORE_DRAIN_FWD_EN defined: ld_chk_hit = ld_chk_vld && any live entry (head through tail-1, including the in-flight head) has the same addr[XLEN-1:2] and nonzero be. Misaligned entries are excluded. The load unit replays the load on a hit.
- STORE_DRAIN_FWD_EN undefined: the ports remain and ld_chk_hit is tied to 0.

## Structure
- mem_pkg holds: sdq_entry_t (extended with data and size), mem_size_e {BYTE, HALF, WORD}, SDQ_ENTRIES, and the drain_state_e FSM enum.
- Sub-module store_drain_buf: the circular buffer with pointers, full/empty, and a read-all-entries port for the forwarding check. store_drain_unit holds lane formation, the FSM and the dmem/SDQ handshakes.

## Test plan
- Single store, WORD 0x1000, data 0xDEADBEEF, idx 3 -> dmem_req in the next cycle with addr 0x1000, be 4'hF, wdata 0xDEADBEEF. After gnt then ack, sdq_free_vld pulses with idx 3.
- BYTE store at 0x1003, data 0x..AB -> be 4'b1000, wdata 0xABABABAB. HALF store at 0x1002, data 0x1234 -> be 4'b1100, wdata 0x12341234.
- HALF store at 0x1001, idx 5 -> no dmem_req, misalign_err pulses, sdq_free_vld pulses with idx 5.
- Hold dmem_gnt low and push 4 stores -> st_ready low after the 4th. Release gnt and ack -> all 4 drain in order with idx 0,1,2,3, and pointers wrap correctly on 4 further stores.
- Assert rst while in WAIT_ACK with 3 entries buffered -> all outputs return to reset values immediately; no sdq_free_vld is emitted.
- With FWD_EN, buffered store to 0x2004 -> ld_chk_addr 0x2006 hits, 0x2008 misses. Without FWD_EN, both miss.
